// File: rtl/lemming_world_if.sv
// Lemming FSM <-> terrain link.
//   master : FSM side (drives walk/aah/digging/jumping, receives terrain status)
//   slave  : terrain side (lemming_world)
interface lemming_world_if;
  logic walk_left;
  logic walk_right;
  logic aah;
  logic digging;
  logic jumping;
  logic bump_left;
  logic bump_right;
  logic small_bump_left;
  logic small_bump_right;
  logic ground;
  logic dig;

  modport master (
    output walk_left, walk_right, aah, digging, jumping,
    input  bump_left, bump_right, small_bump_left, small_bump_right, ground, dig
  );

  modport slave (
    input  walk_left, walk_right, aah, digging, jumping,
    output bump_left, bump_right, small_bump_left, small_bump_right, ground, dig
  );
endinterface

// File: rtl/lemming_world.sv
// Behavioural 1-D terrain closing the loop around the lemming FSM.
// Tracks the lemming column, walls, steps and (diggable) holes, and returns
// bump / small_bump / ground / dig to the FSM. All outputs are registered.
// Ports:
//   clk      rising-edge clock
//   areset   asynchronous active-low reset
//   start    level; leaves IDLE
//   dig_req  player dig command, forwarded one cycle later as fsm.dig
//   fsm      terrain side of lemming_world_if
//   pos_x    current column
//   state_o  IDLE=0 RUN=1 FALL=2 SPLAT=3 SAVED=4
module lemming_world #(
  parameter int unsigned         LEVEL_W     = 16,
  parameter int unsigned         X_W         = 4,
  parameter int unsigned         START_X     = 2,
  parameter logic [LEVEL_W-1:0]  WALL_MAP    = 16'h8001,
  parameter logic [LEVEL_W-1:0]  STEP_MAP    = 16'h0040,
  parameter logic [LEVEL_W-1:0]  HOLE_MAP    = 16'h0400,
  parameter logic [LEVEL_W-1:0]  DIG_MAP     = 16'h0010,
  parameter int unsigned         MOVE_DIV    = 4,
  parameter int unsigned         DIG_CYCLES  = 3,
  parameter int unsigned         FALL_DEPTH  = 5,
  parameter int unsigned         SPLAT_LIMIT = 8
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  input  logic               dig_req,
  lemming_world_if.slave     fsm,
  output logic [X_W-1:0]     pos_x,
  output logic [2:0]         state_o
);

  localparam int unsigned TICK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int unsigned DIG_W  = $clog2(DIG_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FALL  = 3'd2,
    S_SPLAT = 3'd3,
    S_SAVED = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [X_W-1:0]      pos_q, pos_d;
  logic [LEVEL_W-1:0]  holes_q, holes_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DIG_W-1:0]    dig_cnt_q, dig_cnt_d;
  logic [3:0]          fall_cnt_q, fall_cnt_d;
  logic                bump_left_q, bump_left_d;
  logic                bump_right_q, bump_right_d;
  logic                sbump_left_q, sbump_left_d;
  logic                sbump_right_q, sbump_right_d;
  logic                ground_q, ground_d;
  logic                dig_q, dig_d;

  logic                tick;
  logic [X_W-1:0]      left_t, right_t;
  logic                at_left_end, at_right_end;

  always_comb begin
    left_t       = pos_q - 1'b1;
    right_t      = pos_q + 1'b1;
    at_left_end  = (pos_q == '0);
    at_right_end = (pos_q == X_W'(LEVEL_W - 1));
  end

  always_comb begin
    state_d       = state_q;
    pos_d         = pos_q;
    holes_d       = holes_q;
    tick_d        = tick_q;
    dig_cnt_d     = dig_cnt_q;
    fall_cnt_d    = fall_cnt_q;
    bump_left_d   = 1'b0;
    bump_right_d  = 1'b0;
    sbump_left_d  = sbump_left_q;
    sbump_right_d = sbump_right_q;
    ground_d      = ground_q;
    dig_d         = dig_req;
    tick          = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        sbump_left_d  = 1'b0;
        sbump_right_d = 1'b0;
        ground_d      = 1'b1;
        dig_d         = 1'b0;
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        tick          = (tick_q == TICK_W'(MOVE_DIV - 1));
        tick_d        = tick ? '0 : tick_q + 1'b1;
        sbump_left_d  = fsm.walk_left  && !at_left_end  && STEP_MAP[left_t];
        sbump_right_d = fsm.walk_right && !at_right_end && STEP_MAP[right_t];
        ground_d      = !holes_q[pos_q];
        if (!fsm.digging) dig_cnt_d = '0;

        if (holes_q[pos_q]) begin
          state_d = S_FALL;
        end else if (pos_q == X_W'(LEVEL_W - 2)) begin
          state_d = S_SAVED;
        end else if (tick) begin
          // Digging owns the tick, so a completing dig never coincides with a move.
          if (fsm.digging) begin
            if (DIG_MAP[pos_q]) begin
              if (dig_cnt_q == DIG_W'(DIG_CYCLES - 1)) begin
                holes_d[pos_q] = 1'b1;
                dig_cnt_d      = '0;
              end else begin
                dig_cnt_d = dig_cnt_q + 1'b1;
              end
            end
          end else if (fsm.walk_left && !fsm.walk_right) begin
            if (at_left_end || WALL_MAP[left_t]) bump_left_d = 1'b1;
            else if (!STEP_MAP[left_t] || fsm.jumping) pos_d = left_t;
          end else if (fsm.walk_right && !fsm.walk_left) begin
            if (at_right_end || WALL_MAP[right_t]) bump_right_d = 1'b1;
            else if (!STEP_MAP[right_t] || fsm.jumping) pos_d = right_t;
          end
        end
      end

      S_FALL: begin
        sbump_left_d  = 1'b0;
        sbump_right_d = 1'b0;
        if (fall_cnt_q == 4'(FALL_DEPTH - 1)) begin
          holes_d[pos_q] = 1'b0;
          ground_d       = 1'b1;
          fall_cnt_d     = '0;
          state_d        = (FALL_DEPTH >= SPLAT_LIMIT) ? S_SPLAT : S_RUN;
        end else begin
          ground_d = 1'b0;
          if (fall_cnt_q != '1) fall_cnt_d = fall_cnt_q + 1'b1;
        end
      end

      default: ; // SPLAT / SAVED: hold everything, bumps drop, dig still follows dig_req
    endcase
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state_q       <= S_IDLE;
      pos_q         <= X_W'(START_X);
      holes_q       <= HOLE_MAP;
      tick_q        <= '0;
      dig_cnt_q     <= '0;
      fall_cnt_q    <= '0;
      bump_left_q   <= 1'b0;
      bump_right_q  <= 1'b0;
      sbump_left_q  <= 1'b0;
      sbump_right_q <= 1'b0;
      ground_q      <= 1'b1;
      dig_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pos_q         <= pos_d;
      holes_q       <= holes_d;
      tick_q        <= tick_d;
      dig_cnt_q     <= dig_cnt_d;
      fall_cnt_q    <= fall_cnt_d;
      bump_left_q   <= bump_left_d;
      bump_right_q  <= bump_right_d;
      sbump_left_q  <= sbump_left_d;
      sbump_right_q <= sbump_right_d;
      ground_q      <= ground_d;
      dig_q         <= dig_d;
    end
  end

  assign fsm.bump_left        = bump_left_q;
  assign fsm.bump_right       = bump_right_q;
  assign fsm.small_bump_left  = sbump_left_q;
  assign fsm.small_bump_right = sbump_right_q;
  assign fsm.ground           = ground_q;
  assign fsm.dig              = dig_q;
  assign pos_x                = pos_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_lemming_world.sv
// Bench for lemming_world: a default instance checked every cycle against a
// procedural terrain model, plus a FALL_DEPTH=8 instance fed the same inputs.
module tb_lemming_world;
  logic       clk = 1'b0;
  logic       areset, start, dig_req;
  logic [3:0] pos_x, pos_s;
  logic [2:0] state_o, state_s;

  lemming_world_if wif();
  lemming_world_if sif();

  assign sif.walk_left  = wif.walk_left;
  assign sif.walk_right = wif.walk_right;
  assign sif.aah        = wif.aah;
  assign sif.digging    = wif.digging;
  assign sif.jumping    = wif.jumping;

  lemming_world dut (
    .clk(clk), .areset(areset), .start(start), .dig_req(dig_req),
    .fsm(wif), .pos_x(pos_x), .state_o(state_o)
  );

  lemming_world #(.FALL_DEPTH(8)) dut_s (
    .clk(clk), .areset(areset), .start(start), .dig_req(dig_req),
    .fsm(sif), .pos_x(pos_s), .state_o(state_s)
  );

  always #5 clk = ~clk;

  int unsigned n_tot = 0, n_pass = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit [15:0] wall_m = 16'h8001;
  bit [15:0] step_m = 16'h0040;
  bit [15:0] hole_m = 16'h0400;
  bit [15:0] digm_m = 16'h0010;
  localparam int M_FD = 5;
  localparam int M_SPLAT = 8;

  int        m_st, m_pos, m_tick, m_digc, m_fall;
  bit [15:0] m_hole;
  bit        m_bl, m_br, m_sbl, m_sbr, m_gnd, m_dig;

  task automatic model_step(bit r, bit s, bit dq, bit wl, bit wr, bit dg, bit jp);
    int nst;
    bit tk;
    int t;
    if (!r) begin
      m_st = 0; m_pos = 2; m_hole = hole_m; m_tick = 0; m_digc = 0; m_fall = 0;
      m_bl = 0; m_br = 0; m_sbl = 0; m_sbr = 0; m_gnd = 1; m_dig = 0;
      return;
    end
    nst = m_st;
    m_bl = 0; m_br = 0;
    m_dig = dq;
    case (m_st)
      0: begin
        m_sbl = 0; m_sbr = 0; m_gnd = 1; m_dig = 0;
        if (s) nst = 1;
      end
      1: begin
        tk = (m_tick == 3);
        m_tick = (m_tick + 1) % 4;
        m_sbl = wl && m_pos > 0  && step_m[m_pos-1];
        m_sbr = wr && m_pos < 15 && step_m[m_pos+1];
        m_gnd = !m_hole[m_pos];
        if (!dg) m_digc = 0;
        if (m_hole[m_pos]) nst = 2;
        else if (m_pos == 14) nst = 4;
        else if (tk) begin
          if (dg) begin
            if (digm_m[m_pos]) begin
              m_digc++;
              if (m_digc == 3) begin m_hole[m_pos] = 1; m_digc = 0; end
            end
          end else if (wl != wr) begin
            t = wl ? m_pos - 1 : m_pos + 1;
            if (t < 0 || t > 15 || wall_m[t]) begin
              if (wl) m_bl = 1; else m_br = 1;
            end else if (!step_m[t] || jp) m_pos = t;
          end
        end
      end
      2: begin
        m_sbl = 0; m_sbr = 0;
        if (m_fall == M_FD - 1) begin
          m_hole[m_pos] = 0; m_gnd = 1; m_fall = 0;
          nst = (M_FD >= M_SPLAT) ? 3 : 1;
        end else begin
          m_gnd = 0;
          if (m_fall < 15) m_fall++;
        end
      end
      default: ;
    endcase
    m_st = nst;
  endtask

  function automatic logic [31:0] dut_vec();
    return {19'd0, state_o, pos_x, wif.ground, wif.bump_left, wif.bump_right,
            wif.small_bump_left, wif.small_bump_right, wif.dig};
  endfunction

  function automatic logic [31:0] model_vec();
    logic [2:0] st = m_st[2:0];
    logic [3:0] ps = m_pos[3:0];
    return {19'd0, st, ps, m_gnd, m_bl, m_br, m_sbl, m_sbr, m_dig};
  endfunction

  // One clock: capture inputs, advance DUT and model, compare after the edge.
  task automatic cyc();
    bit r = areset, s = start, dq = dig_req;
    bit wl = wif.walk_left, wr = wif.walk_right, dg = wif.digging, jp = wif.jumping;
    @(posedge clk);
    model_step(r, s, dq, wl, wr, dg, jp);
    #1;
    chk("model", dut_vec(), model_vec());
  endtask

  task automatic wait_pos(int target, int budget, string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      cyc();
      if (pos_x == 4'(target)) hit = 1;
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic clr_in();
    start = 0; dig_req = 0;
    wif.walk_left = 0; wif.walk_right = 0; wif.aah = 0; wif.digging = 0; wif.jumping = 0;
  endtask

  task automatic do_reset();
    clr_in();
    areset = 0;
    cyc(); cyc();
    areset = 1; start = 1;
    cyc();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit rst_n, st, dq, wl;
    int e_state, e_pos;
    bit e_gnd, e_bl, e_dig;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nf;
    tbl[0]  = '{0, 0, 0, 0, 0, 2, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 0, 0, 2, 1, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 1, 2, 1, 0, 0};
    tbl[3]  = '{1, 1, 1, 1, 1, 2, 1, 0, 1};
    tbl[4]  = '{1, 1, 0, 1, 1, 2, 1, 0, 0};
    tbl[5]  = '{1, 1, 0, 1, 1, 2, 1, 0, 0};
    tbl[6]  = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
    tbl[8]  = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
    tbl[9]  = '{1, 1, 0, 1, 1, 1, 1, 0, 0};
    tbl[10] = '{1, 1, 0, 1, 1, 1, 1, 1, 0};
    tbl[11] = '{1, 1, 0, 1, 1, 1, 1, 0, 0};

    clr_in();
    areset = 0;
    foreach (tbl[i]) begin
      areset = tbl[i].rst_n; start = tbl[i].st; dig_req = tbl[i].dq;
      wif.walk_left = tbl[i].wl;
      cyc();
      chk($sformatf("tbl%0d_state", i), 32'(state_o), 32'(tbl[i].e_state));
      chk($sformatf("tbl%0d_pos", i),   32'(pos_x),   32'(tbl[i].e_pos));
      chk($sformatf("tbl%0d_ground", i), 32'(wif.ground), 32'(tbl[i].e_gnd));
      chk($sformatf("tbl%0d_bump_l", i), 32'(wif.bump_left), 32'(tbl[i].e_bl));
      chk($sformatf("tbl%0d_dig", i),   32'(wif.dig), 32'(tbl[i].e_dig));
    end

    // Step, hole fall, splat variant, saved
    do_reset();
    wif.walk_right = 1;
    wait_pos(5, 20, "reach5");
    repeat (8) cyc();
    chk("step_hold_pos", 32'(pos_x), 32'd5);
    chk("small_bump_r", 32'(wif.small_bump_right), 32'd1);
    wif.jumping = 1;
    wait_pos(6, 8, "jump6");
    wif.jumping = 0;
    wait_pos(10, 24, "reach10");
    chk("arrive_ground", 32'(wif.ground), 32'd1);
    cyc();
    chk("hole_ground", 32'(wif.ground), 32'd0);
    chk("hole_state", 32'(state_o), 32'd2);
    nf = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (state_o != 3'd2) break;
      nf++;
    end
    chk("fall_len", 32'(nf), 32'd5);
    chk("land_state", 32'(state_o), 32'd1);
    chk("land_ground", 32'(wif.ground), 32'd1);
    wif.walk_right = 0;
    repeat (8) cyc();
    chk("floor_state", 32'(state_o), 32'd1);
    chk("splat_state", 32'(state_s), 32'd3);
    chk("splat_ground", 32'(sif.ground), 32'd1);
    wif.walk_right = 1;
    wait_pos(14, 24, "reach14");
    cyc();
    chk("saved_state", 32'(state_o), 32'd4);
    repeat (8) cyc();
    chk("saved_pos", 32'(pos_x), 32'd14);
    chk("saved_bump_r", 32'(wif.bump_right), 32'd0);
    chk("splat_frozen_pos", 32'(pos_s), 32'd10);
    chk("splat_frozen_st", 32'(state_s), 32'd3);

    // Dig: non-diggable column 3, diggable column 4
    do_reset();
    wif.walk_right = 1;
    wait_pos(3, 8, "reach3");
    wif.walk_right = 0; wif.digging = 1;
    repeat (16) cyc();
    chk("nodig_ground", 32'(wif.ground), 32'd1);
    chk("nodig_pos", 32'(pos_x), 32'd3);
    wif.digging = 0; wif.walk_right = 1;
    wait_pos(4, 8, "reach4");
    wif.walk_right = 0; wif.digging = 1;
    repeat (12) cyc();
    chk("dig_pre_ground", 32'(wif.ground), 32'd1);
    cyc();
    chk("dig_ground", 32'(wif.ground), 32'd0);
    chk("dig_fall", 32'(state_o), 32'd2);
    wif.digging = 0;
    repeat (5) cyc();
    chk("dig_land", 32'(state_o), 32'd1);

    // Reset during fall restores the level
    do_reset();
    wif.walk_right = 1; wif.jumping = 1;
    wait_pos(10, 40, "reach10b");
    cyc();
    chk("restored_hole", 32'(state_o), 32'd2);
    cyc(); cyc();
    areset = 0;
    cyc();
    chk("midfall_rst_state", 32'(state_o), 32'd0);
    chk("midfall_rst_pos", 32'(pos_x), 32'd2);
    chk("midfall_rst_gnd", 32'(wif.ground), 32'd1);
    areset = 1;

    // Randomised closed-loop stimulus against the model
    for (int i = 0; i < 1600; i++) begin
      areset = ($urandom_range(0, 199) != 0);
      if (i % 4 == 0) begin
        start          = ($urandom_range(0, 3) != 0);
        dig_req        = 1'($urandom_range(0, 1));
        wif.walk_left  = ($urandom_range(0, 2) == 0);
        wif.walk_right = ($urandom_range(0, 1) == 0);
        wif.digging    = ($urandom_range(0, 3) == 0);
        wif.jumping    = 1'($urandom_range(0, 1));
        wif.aah        = 1'($urandom_range(0, 1));
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
